// File: rtl/trasmision_pkg.sv
// Shared definitions for the 11-bit serial frame transmitter.
package trasmision_pkg;

    // Bits per serial frame: start bit, nine payload/parity bits, stop bit.
    localparam int FRAME_BITS = 11;

    // Bit counter spans 0..FRAME_BITS-1.
    localparam int BIT_CNT_W = $clog2(FRAME_BITS);

    // Baud counter spans 0..CLKS_PER_BIT-1 with CLKS_PER_BIT up to 65535.
    localparam int BAUD_CNT_W = 16;

    // Transmitter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A transfer is requested only when qualified and in the write direction.
    function automatic logic is_write_request(input logic enable, input logic rw);
        return enable & rw;
    endfunction

endpackage

// File: rtl/trasmision_baud_gen.sv
// Bit-period timer: pulses bit_tick_o on the last cycle of every bit period
// while the transmitter is shifting, and restarts from zero on each frame start.
module trasmision_baud_gen
    import trasmision_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic restart_i,
    output logic bit_tick_o
);

    localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    // Next count: held at zero when idle or restarting, wraps at the end of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The tick marks the final cycle of the current bit; it only reaches the
    // FSM, the block outputs stay purely registered.
    assign bit_tick_o = en_i && !restart_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/trasmision.sv
// Serial frame transmitter: accepts a pre-assembled 11-bit frame and shifts it
// out LSB first on Tx, each bit held CLKS_PER_BIT cycles, followed by a
// single-cycle done pulse. Tx, busy and done all come straight from flops.
module trasmision #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FRAME_BITS   = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] din,
    input  logic                  enable,
    input  logic                  RW,
    output logic                  Tx,
    output logic                  done,
    output logic                  busy
);

    import trasmision_pkg::*;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    state_t                 state_q;
    logic [FRAME_BITS-1:0]  shreg_q;     // bits still to be sent, next one in [0]
    logic [BIT_CNT_W-1:0]   bit_cnt_q;   // index of the bit currently on Tx
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   shifting;
    logic                   bit_tick;

    // Requests are only looked at in IDLE; DONE and SHIFT ignore them.
    assign accept   = (state_q == IDLE) && is_write_request(enable, RW);
    assign shifting = (state_q == SHIFT);

    trasmision_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (shifting),
        .restart_i  (accept),
        .bit_tick_o (bit_tick)
    );

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        // Bit 0 goes straight onto the line; the rest wait in
                        // the shift register with zeros filling from the top.
                        tx_q      <= din[0];
                        shreg_q   <= {1'b0, din[FRAME_BITS-1:1]};
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            tx_q      <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= DONE;
                        end else begin
                            tx_q      <= shreg_q[0];
                            shreg_q   <= {1'b0, shreg_q[FRAME_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // One-cycle stop state; always returns to IDLE so a held
                    // request starts the next frame one cycle later.
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    shreg_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign Tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_trasmision.sv
// Bench for trasmision: two instances (1 and 4 clocks per bit) driven from one
// directed/randomized sequence; expectations come from the frame rules (bit k
// of din on the line for CLKS_PER_BIT cycles, then a one-cycle done pulse).
module tb_trasmision;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] din;
    logic        req_en;
    logic        rw;
    logic        sel4;

    logic        en1, en4;
    logic        tx1, done1, busy1;
    logic        tx4, done4, busy4;
    logic        tx_o, done_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees requests; the other stays idle.
    assign en1    = req_en & ~sel4;
    assign en4    = req_en & sel4;
    assign tx_o   = sel4 ? tx4   : tx1;
    assign done_o = sel4 ? done4 : done1;
    assign busy_o = sel4 ? busy4 : busy1;

    trasmision #(.CLKS_PER_BIT(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .enable (en1),
        .RW     (rw),
        .Tx     (tx1),
        .done   (done1),
        .busy   (busy1)
    );

    trasmision #(.CLKS_PER_BIT(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .enable (en4),
        .RW     (rw),
        .Tx     (tx4),
        .done   (done4),
        .busy   (busy4)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_line(input string tag, input logic tx_e, input logic busy_e, input logic done_e);
        chk({tag, ".Tx"},   tx_o,   tx_e);
        chk({tag, ".busy"}, busy_o, busy_e);
        chk({tag, ".done"}, done_o, done_e);
    endtask

    // Present a request at the current falling edge (DUT must be in IDLE), then
    // check every cycle of the frame. noise: 0 none, 1 random input churn,
    // 2 din forced to 7FF halfway. hold keeps the request asserted.
    // Returns at the falling edge of the done cycle after checking it.
    task automatic send_frame(input logic [10:0] frame, input int cpb, input int noise, input bit hold);
        din    = frame;
        req_en = 1'b1;
        rw     = 1'b1;
        @(negedge clk);
        if (!hold) begin
            req_en = 1'b0;
            rw     = 1'b0;
        end
        for (int i = 0; i < 11 * cpb; i++) begin
            expect_line("shift", frame[i / cpb], 1'b1, 1'b0);
            if (noise == 1) begin
                din    = 11'($urandom);
                req_en = 1'($urandom);
                rw     = 1'($urandom);
            end else if (noise == 2 && i == 5 * cpb) begin
                din = 11'h7FF;
            end
            @(negedge clk);
        end
        expect_line("done_cycle", 1'b1, 1'b0, 1'b1);
        $display("frame din=%b cpb=%0d noise=%0d hold=%0d checked", frame, cpb, noise, hold);
    endtask

    // Drop any request and check one quiet IDLE cycle.
    task automatic settle(input string tag);
        req_en = 1'b0;
        rw     = 1'b0;
        @(negedge clk);
        expect_line(tag, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [10:0] frame;
        int          gap;

        rst    = 1'b1;
        din    = '1;
        req_en = 1'b0;
        rw     = 1'b0;
        sel4   = 1'b0;

        // Reset state before any clock edge, for both instances.
        #1;
        chk("rst_async.Tx1",   tx1,   1'b1);
        chk("rst_async.busy1", busy1, 1'b0);
        chk("rst_async.done1", done1, 1'b0);
        chk("rst_async.Tx4",   tx4,   1'b1);
        chk("rst_async.busy4", busy4, 1'b0);
        chk("rst_async.done4", done4, 1'b0);

        repeat (3) @(negedge clk);
        expect_line("rst_held", 1'b1, 1'b0, 1'b0);

        // First request after reset release is taken on the very next edge.
        rst = 1'b0;
        send_frame(11'b10010101010, 1, 0, 0);
        settle("after_basic");

        // enable low: nothing happens.
        req_en = 1'b0;
        rw     = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expect_line("en0_rw1", 1'b1, 1'b0, 1'b0);
        end

        // RW low: nothing happens.
        req_en = 1'b1;
        rw     = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expect_line("en1_rw0", 1'b1, 1'b0, 1'b0);
        end
        settle("after_noop");

        // Four clocks per bit; din overwritten mid-frame must not matter.
        sel4 = 1'b1;
        send_frame(11'b10010101010, 4, 2, 0);
        settle("after_cpb4");

        // Request held continuously: back-to-back frames with two idle-high cycles.
        sel4 = 1'b0;
        send_frame(11'b11100110100, 1, 0, 1);
        @(negedge clk);
        expect_line("b2b_gap", 1'b1, 1'b0, 1'b0);
        send_frame(11'b11100110100, 1, 0, 1);
        settle("after_b2b");

        // Asynchronous reset at bit 5 aborts the frame with no done pulse.
        frame  = 11'b10000000000;
        din    = frame;
        req_en = 1'b1;
        rw     = 1'b1;
        @(negedge clk);
        req_en = 1'b0;
        rw     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_line("pre_abort", frame[i], 1'b1, 1'b0);
            @(negedge clk);
        end
        expect_line("bit5", frame[5], 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_line("abort_now", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        expect_line("abort_held", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            expect_line("after_abort", 1'b1, 1'b0, 1'b0);
        end
        send_frame(11'b10110011010, 1, 0, 0);
        settle("after_recover");

        // Randomized frames on both instances with idle gaps and input churn.
        for (int n = 0; n < 24; n++) begin
            sel4 = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 0) begin
                    req_en = 1'b1;
                    rw     = 1'b0;
                end else begin
                    req_en = 1'b0;
                    rw     = 1'b1;
                end
                din = 11'($urandom);
                @(negedge clk);
                expect_line("rand_gap", 1'b1, 1'b0, 1'b0);
            end
            frame = {1'b1, 9'($urandom), 1'b0};
            send_frame(frame, sel4 ? 4 : 1, 1, 0);
            settle("rand_after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
